eeprom_i2c_resp: RTL and testbench

- Synthesizable two-wire serial EEPROM responder (target side).
- Answers the team's EEPROM_WR master: 2 kB array, control byte 1010_A[10:8]_R/W, one address byte, byte/page write, current and random read.
- Used as the bench and FPGA-side memory model for master verification.
- Oversamples SCL/SDA on CLK; never drives SCL.

---
 rtl/eeprom_i2c_resp.sv | 223 ++++++++++++++++++++++
 tb/tb_eeprom_i2c_resp.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_i2c_resp.sv
// Two-wire serial EEPROM responder: a 2**MEM_AW byte array addressed by a 1010_AAA_RW control
// byte plus one address byte. SCL/SDA are oversampled on CLK; SDA is only ever pulled low.
module eeprom_i2c_resp #(
    parameter int         MEM_AW    = 11,
    parameter int         PAGE_BITS = 4,
    parameter logic [3:0] DEV_ID    = 4'b1010
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCL,
    inout  wire               SDA,
    output logic              BUSY,
    output logic              WR_STB,
    output logic [MEM_AW-1:0] WR_ADDR,
    output logic [7:0]        WR_DATA
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CTRL, ST_ADDR, ST_WDATA, ST_ACK, ST_RLOAD, ST_RD, ST_RACK
    } state_t;

    logic [7:0] mem [0:(2**MEM_AW)-1];

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    logic              ack_on_q, ack_on_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [MEM_AW-1:0] ptr_q, ptr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              busy_q, busy_d;
    logic              wr_stb_q, wr_stb_d;
    logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              mem_we;
    logic              load_rd;
    logic [7:0]        rx_byte;
    logic [7:0]        rd_byte;

    logic scl_rise, scl_fall, start_cond, stop_cond;

    // Input synchronizers plus one history stage; the bus idles high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= SCL;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= SDA;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    assign scl_rise   = scl_s2_q & ~scl_h_q;
    assign scl_fall   = ~scl_s2_q & scl_h_q;
    assign start_cond = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_cond  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;

    assign rx_byte = {shreg_q[6:0], sda_s2_q};
    assign rd_byte = mem[ptr_q];

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        ack_on_d  = ack_on_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        load_rd   = 1'b0;

        if (start_cond) begin
            state_d   = ST_CTRL;
            bit_cnt_d = 3'd0;
            ack_on_d  = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_cond) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            ack_on_d  = 1'b0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_CTRL: if (scl_rise) begin
                    shreg_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (rx_byte[7:4] == DEV_ID) begin
                            ptr_d[MEM_AW-1:8] = rx_byte[MEM_AW-8:1];
                            ret_d   = rx_byte[0] ? ST_RLOAD : ST_ADDR;
                            state_d = ST_ACK;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR: if (scl_rise) begin
                    shreg_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        ptr_d[7:0] = rx_byte;
                        ret_d      = ST_WDATA;
                        state_d    = ST_ACK;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    shreg_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        mem_we    = 1'b1;
                        wr_stb_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = rx_byte;
                        // only the in-page offset advances; the page stays put
                        ptr_d[PAGE_BITS-1:0] = ptr_q[PAGE_BITS-1:0] + PAGE_BITS'(1);
                        ret_d   = ST_WDATA;
                        state_d = ST_ACK;
                    end
                end
                ST_ACK: if (scl_fall) begin
                    if (!ack_on_q) begin
                        sda_oe_d = 1'b1;
                        ack_on_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        ack_on_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (ret_q == ST_RLOAD) begin
                            load_rd = 1'b1;
                        end else begin
                            state_d = ret_q;
                        end
                    end
                end
                ST_RLOAD: if (scl_fall) begin
                    load_rd = 1'b1;
                end
                ST_RD: if (scl_fall) begin
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d  = 1'b0;
                        ptr_d     = ptr_q + MEM_AW'(1);
                        bit_cnt_d = 3'd0;
                        state_d   = ST_RACK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shreg_d   = {shreg_q[6:0], shreg_q[7]};
                        sda_oe_d  = ~shreg_q[6];
                    end
                end
                ST_RACK: if (scl_rise) begin
                    state_d = sda_s2_q ? ST_IDLE : ST_RLOAD;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Launch a read byte: MSB goes on the bus at this same SCL fall.
        if (load_rd) begin
            shreg_d   = rd_byte;
            sda_oe_d  = ~rd_byte[7];
            bit_cnt_d = 3'd0;
            state_d   = ST_RD;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            ack_on_q  <= 1'b0;
            bit_cnt_q <= 3'd0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            ack_on_q  <= ack_on_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Data-only storage: the shifter and the array keep their contents through reset.
    always_ff @(posedge CLK) begin
        shreg_q <= shreg_d;
        if (mem_we && !RESET) begin
            mem[ptr_q] <= rx_byte;
        end
    end

    assign SDA     = sda_oe_q ? 1'b0 : 1'bz;
    assign BUSY    = busy_q;
    assign WR_STB  = wr_stb_q;
    assign WR_ADDR = wr_addr_q;
    assign WR_DATA = wr_data_q;

endmodule

// File: tb/tb_eeprom_i2c_resp.sv
// Scoreboard bench for eeprom_i2c_resp: a bit-banged bus master, a byte-level memory model,
// and a monitor that checks every write strobe and every byte read back off the bus.
module tb_eeprom_i2c_resp;
    localparam int Q = 40;

    typedef struct packed {
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        m_sda_low = 1'b0;
    wire         sda;
    logic        busy, wr_stb;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;

    int total = 0;
    int bad   = 0;

    wr_t        wr_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] rd_obs_q[$];
    logic [7:0] ref_mem [0:2047];
    int         ref_ptr = 0;
    logic [7:0] wdata [0:31];

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    eeprom_i2c_resp dut (
        .CLK(clk), .RESET(rst), .SCL(scl), .SDA(sda),
        .BUSY(busy), .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_DATA(wr_data)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: consumes expectations as the DUT produces strobes / read bytes.
    always @(negedge clk) begin
        wr_t        e;
        logic [7:0] o, x;
        if (wr_stb) begin
            if (wr_exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: got addr=%0h data=%0h want no strobe", wr_addr, wr_data);
            end else begin
                e = wr_exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.a));
                check("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
        if (rd_obs_q.size() > 0) begin
            o = rd_obs_q.pop_front();
            if (rd_exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got %0h want no byte", o);
            end else begin
                x = rd_exp_q.pop_front();
                check("rd_byte", 32'(o), 32'(x));
            end
        end
    end

    task automatic bit_w(input logic b);
        m_sda_low = ~b;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
        #Q;
    endtask

    task automatic bit_r(output logic b);
        m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q b = sda;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_start;
        m_sda_low = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b1;
        #Q scl = 1'b0;
        #Q;
    endtask

    task automatic i2c_stop;
        m_sda_low = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda_low = 1'b0;
        #(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] v, input logic exp_ack, input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) bit_w(v[i]);
        bit_r(a);
        check(nm, 32'(a), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic nack);
        logic [7:0] v;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            v[i] = b;
        end
        bit_w(nack);
        rd_obs_q.push_back(v);
    endtask

    task automatic do_write(input int a0, input int n);
        int  ai;
        wr_t e;
        i2c_start;
        check("busy_start", 32'(busy), 32'd1);
        send_byte({4'b1010, 3'(a0 >> 8), 1'b0}, 1'b0, "ack_ctrl_w");
        send_byte(8'(a0), 1'b0, "ack_addr");
        for (int i = 0; i < n; i++) begin
            ai = (a0 & ~15) | ((a0 + i) & 15);
            e.a = 11'(ai);
            e.d = wdata[i];
            wr_exp_q.push_back(e);
            ref_mem[ai] = wdata[i];
            send_byte(wdata[i], 1'b0, "ack_data");
        end
        ref_ptr = (a0 & ~15) | ((a0 + n) & 15);
        i2c_stop;
        check("busy_stop", 32'(busy), 32'd0);
    endtask

    task automatic read_n(input int a0, input int n);
        for (int i = 0; i < n; i++) begin
            rd_exp_q.push_back(ref_mem[(a0 + i) % 2048]);
            read_byte(i == n - 1);
        end
        ref_ptr = (a0 + n) % 2048;
        check("sda_rel_nack", 32'(sda), 32'd1);
        i2c_stop;
    endtask

    task automatic do_rand_read(input int a0, input int n);
        i2c_start;
        send_byte({4'b1010, 3'(a0 >> 8), 1'b0}, 1'b0, "ack_ctrl_w");
        send_byte(8'(a0), 1'b0, "ack_addr");
        i2c_start;
        send_byte({4'b1010, 3'(a0 >> 8), 1'b1}, 1'b0, "ack_ctrl_r");
        read_n(a0, n);
    endtask

    task automatic do_cur_read(input int hi, input int n);
        i2c_start;
        send_byte({4'b1010, 3'(hi), 1'b1}, 1'b0, "ack_ctrl_r");
        read_n((hi << 8) | (ref_ptr & 255), n);
    endtask

    initial begin
        int base, s, n, off;

        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_stb", 32'(wr_stb), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_sda", 32'(sda), 32'd1);
        @(negedge clk) rst = 1'b0;
        #(4*Q);

        // single byte write
        wdata[0] = 8'h3E;
        do_write(11'h25C, 1);

        // page wrap: 18 bytes starting two below the page end
        for (int i = 0; i < 18; i++) wdata[i] = 8'(i);
        do_write(11'h10E, 18);
        do_rand_read(11'h10F, 1);

        // random read wrapping across the top of the array
        wdata[0] = 8'hA5;
        do_write(11'h7FF, 1);
        wdata[0] = 8'h3C;
        do_write(11'h000, 1);
        do_rand_read(11'h7FF, 2);

        // wrong device id, then a normal transaction must still work
        i2c_start;
        send_byte(8'h62, 1'b1, "nack_bad_id");
        i2c_stop;
        check("busy_bad_id", 32'(busy), 32'd0);

        // STOP in the middle of a data byte
        i2c_start;
        send_byte(8'hA4, 1'b0, "ack_ctrl_w");
        send_byte(8'h5C, 1'b0, "ack_addr");
        bit_w(1'b1);
        bit_w(1'b0);
        bit_w(1'b1);
        bit_w(1'b0);
        i2c_stop;
        check("busy_early_stop", 32'(busy), 32'd0);
        do_rand_read(11'h25C, 1);

        // reset while the responder is pulling SDA low for bit7 of 0x3C
        i2c_start;
        send_byte(8'hA0, 1'b0, "ack_ctrl_w");
        send_byte(8'h00, 1'b0, "ack_addr");
        i2c_start;
        send_byte(8'hA1, 1'b0, "ack_ctrl_r");
        #(2*Q);
        check("rd_drive_low", 32'(sda), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_sda", 32'(sda), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_wr_stb", 32'(wr_stb), 32'd0);
        @(negedge clk) rst = 1'b0;
        ref_ptr = 0;
        #(2*Q);
        i2c_stop;

        // randomized pages: full-page fill, wrapping overwrite, random + current read
        for (int it = 0; it < 4; it++) begin
            base = int'($urandom_range(0, 127)) * 16;
            s = int'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) wdata[i] = 8'($urandom);
            do_write(base + s, 16);
            s = int'($urandom_range(0, 15));
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
            do_write(base + s, n);
            off = int'($urandom_range(0, 12));
            n = int'($urandom_range(1, 3));
            do_rand_read(base + off, n);
            do_cur_read(base >> 8, 1);
        end

        repeat (20) @(posedge clk);
        #1;
        check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
